// File: rtl/seq_alu_unit.sv
// Multi-cycle WIDTH-bit ALU: single-cycle ADD/SUB, iterative one-bit-per-clock SHL/SHR-arithmetic.
// Optional macro SEQ_ALU_SAT_EN makes ADD/SUB results saturate on signed overflow.
module seq_alu_unit #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic [WIDTH-1:0]   A_i,
    input  logic [WIDTH-1:0]   B_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   Y_o,
    output logic               cout_o,
    output logic               ovfl_o,
    output logic               zero_o
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               shr_q, shr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cout_q, cout_d;
    logic               ovfl_q, ovfl_d;

    logic               isSub;
    logic [WIDTH-1:0]   opB;
    logic [WIDTH:0]     sum;
    logic               arithOvfl;
    logic [WIDTH-1:0]   arithY;

    // Subtraction is A + ~B + 1, so one adder serves both arithmetic modes.
    assign isSub     = mode_i[0];
    assign opB       = isSub ? ~B_i : B_i;
    assign sum       = {1'b0, A_i} + {1'b0, opB} + {{WIDTH{1'b0}}, isSub};
    assign arithOvfl = (A_i[WIDTH-1] == opB[WIDTH-1]) && (sum[WIDTH-1] != A_i[WIDTH-1]);

`ifdef SEQ_ALU_SAT_EN
    always_comb begin
        arithY = sum[WIDTH-1:0];
        if (arithOvfl) begin
            arithY = A_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign arithY = sum[WIDTH-1:0];
`endif

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        shr_d   = shr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        ovfl_d  = ovfl_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (mode_i[1]) begin
                        y_d    = arithY;
                        cout_d = sum[WIDTH];
                        ovfl_d = arithOvfl;
                        done_d = 1'b1;
                    end else begin
                        y_d    = B_i;
                        cout_d = 1'b0;
                        ovfl_d = 1'b0;
                        shr_d  = mode_i[0];
                        if (shamt_i == '0) begin
                            done_d = 1'b1;
                        end else begin
                            cnt_d   = shamt_i;
                            busy_d  = 1'b1;
                            state_d = SHIFT;
                        end
                    end
                end
            end
            SHIFT: begin
                // Direction comes from the latched mode; live inputs may change while busy.
                if (shr_q) begin
                    cout_d = y_q[0];
                    y_d    = {y_q[WIDTH-1], y_q[WIDTH-1:1]};
                end else begin
                    cout_d = y_q[WIDTH-1];
                    y_d    = {y_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SHAMT_W'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            cnt_q   <= '0;
            shr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovfl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            shr_q   <= shr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovfl_q  <= ovfl_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign Y_o    = y_q;
    assign cout_o = cout_q;
    assign ovfl_o = ovfl_q;
    assign zero_o = (y_q == '0);

endmodule

// File: tb/tb_seq_alu_unit.sv
// Self-checking bench for seq_alu_unit (WIDTH=16): vector table plus scoreboard, and
// hand-written sequences for busy-start, back-to-back and mid-shift reset cases.
module tb_seq_alu_unit;

    localparam int W = 16;

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   shamt;
        logic [W-1:0] y;
        logic [W-1:0] ySat;
        logic         cout;
        logic         ovfl;
        string        name;
    } vec_t;

    typedef struct {
        logic [W-1:0] y;
        logic         cout;
        logic         ovfl;
        string        name;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   shamt;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic         cout;
    logic         ovfl;
    logic         zero;

    int   assertCount = 0;
    int   failCount   = 0;
    int   doneCount   = 0;
    exp_t expQ[$];
    vec_t vecs[14];

    seq_alu_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .mode_i  (mode),
        .A_i     (a),
        .B_i     (b),
        .shamt_i (shamt),
        .busy_o  (busy),
        .done_o  (done),
        .Y_o     (y),
        .cout_o  (cout),
        .ovfl_o  (ovfl),
        .zero_o  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] required);
        assertCount++;
        if (actual !== required) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
        end
    endtask

    // Drives one operation at posedge+1, pushes its expectation, and waits for done.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        int   edges;
        int   expLat;
        e.y    = v.y;
`ifdef SEQ_ALU_SAT_EN
        e.y    = v.ySat;
`endif
        e.cout = v.cout;
        e.ovfl = v.ovfl;
        e.name = v.name;
        expLat = (!v.mode[1] && v.shamt != 0) ? int'(v.shamt) + 1 : 1;
        mode   = v.mode;
        a      = v.a;
        b      = v.b;
        shamt  = v.shamt;
        start  = 1'b1;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
        if (expLat > 1) checkOutput({v.name, "_busy"}, {15'b0, busy}, 16'd1);
        while (done !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput({v.name, "_latency"}, W'(edges), W'(expLat));
    endtask

    initial begin
        vecs[0]  = '{2'b10, 16'h7FFF, 16'h0001, 4'd0,  16'h8000, 16'h7FFF, 1'b0, 1'b1, "addOvfl"};
        vecs[1]  = '{2'b11, 16'h0003, 16'h0005, 4'd0,  16'hFFFE, 16'hFFFE, 1'b0, 1'b0, "subNeg"};
        vecs[2]  = '{2'b11, 16'h1234, 16'h1234, 4'd0,  16'h0000, 16'h0000, 1'b1, 1'b0, "subZero"};
        vecs[3]  = '{2'b01, 16'h0000, 16'h8001, 4'd3,  16'hF000, 16'hF000, 1'b0, 1'b0, "shr3"};
        vecs[4]  = '{2'b00, 16'h0000, 16'h0003, 4'd15, 16'h8000, 16'h8000, 1'b1, 1'b0, "shl15"};
        vecs[5]  = '{2'b00, 16'h5555, 16'hABCD, 4'd0,  16'hABCD, 16'hABCD, 1'b0, 1'b0, "shl0"};
        vecs[6]  = '{2'b10, 16'hFFFF, 16'h0001, 4'd0,  16'h0000, 16'h0000, 1'b1, 1'b0, "addCarry"};
        vecs[7]  = '{2'b10, 16'h8000, 16'h8000, 4'd0,  16'h0000, 16'h8000, 1'b1, 1'b1, "addNegOvfl"};
        vecs[8]  = '{2'b11, 16'h8000, 16'h0001, 4'd0,  16'h7FFF, 16'h8000, 1'b1, 1'b1, "subNegOvfl"};
        vecs[9]  = '{2'b11, 16'h7FFF, 16'hFFFF, 4'd0,  16'h8000, 16'h7FFF, 1'b0, 1'b1, "subPosOvfl"};
        vecs[10] = '{2'b01, 16'h0000, 16'h7FF0, 4'd4,  16'h07FF, 16'h07FF, 1'b0, 1'b0, "shr4"};
        vecs[11] = '{2'b00, 16'h0000, 16'h1234, 4'd1,  16'h2468, 16'h2468, 1'b0, 1'b0, "shl1"};
        vecs[12] = '{2'b01, 16'h0000, 16'hFFFF, 4'd15, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "shr15"};
        vecs[13] = '{2'b10, 16'h1234, 16'h4321, 4'd0,  16'h5555, 16'h5555, 1'b0, 1'b0, "addPlain"};

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 2'b00;
        a     = '0;
        b     = '0;
        shamt = '0;

        // Scoreboard: every done pulse must match the oldest pending expectation.
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (done === 1'b1) begin
                    doneCount++;
                    if (expQ.size() == 0) begin
                        assertCount++;
                        failCount++;
                        $display("[TB] FAIL unexpectedDone: done=1 required=0 y=%h", y);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput({e.name, "_y"},    y,               e.y);
                        checkOutput({e.name, "_cout"}, {15'b0, cout},   {15'b0, e.cout});
                        checkOutput({e.name, "_ovfl"}, {15'b0, ovfl},   {15'b0, e.ovfl});
                        checkOutput({e.name, "_zero"}, {15'b0, zero},   {15'b0, (e.y == 16'h0)});
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstY",    y,             16'h0000);
        checkOutput("rstBusy", {15'b0, busy}, 16'd0);
        checkOutput("rstDone", {15'b0, done}, 16'd0);
        checkOutput("rstCout", {15'b0, cout}, 16'd0);
        checkOutput("rstOvfl", {15'b0, ovfl}, 16'd0);
        checkOutput("rstZero", {15'b0, zero}, 16'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back: each call launches in the done cycle of the previous one.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
        end

        // Start pulsed while busy must be ignored.
        begin
            int edges;
            mode  = 2'b00;
            b     = 16'h0003;
            shamt = 4'd8;
            start = 1'b1;
            expQ.push_back('{16'h0300, 1'b0, 1'b0, "shlIgnoreStart"});
            @(posedge clk);
            #1;
            start = 1'b0;
            edges = 1;
            repeat (3) begin
                @(posedge clk);
                #1;
                edges++;
            end
            mode  = 2'b10;
            a     = 16'h1111;
            b     = 16'h2222;
            shamt = 4'd2;
            start = 1'b1;
            @(posedge clk);
            #1;
            edges++;
            start = 1'b0;
            b     = 16'hFFFF;
            checkOutput("busyAfterIgnoredStart", {15'b0, busy}, 16'd1);
            while (done !== 1'b1 && edges < 40) begin
                @(posedge clk);
                #1;
                edges++;
            end
            checkOutput("ignoreStartLatency", W'(edges), 16'd9);
        end
        applyStimulus('{2'b10, 16'h0100, 16'h0023, 4'd0, 16'h0123, 16'h0123, 1'b0, 1'b0, "addAfterShift"});
        @(posedge clk);
        #1;

        // Asynchronous reset mid-shift (cnt=5) aborts with no later done.
        begin
            int doneBefore;
            mode  = 2'b00;
            b     = 16'hFFFF;
            shamt = 4'd10;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (5) @(posedge clk);
            #3;
            doneBefore = doneCount;
            rst_n = 1'b0;
            #1;
            checkOutput("midRstY",    y,             16'h0000);
            checkOutput("midRstBusy", {15'b0, busy}, 16'd0);
            checkOutput("midRstDone", {15'b0, done}, 16'd0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            repeat (20) @(posedge clk);
            #1;
            checkOutput("noDoneAfterRst", W'(doneCount), W'(doneBefore));
            checkOutput("zeroAfterRst",   {15'b0, zero}, 16'd1);
        end

        assertCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL pendingResults: actual=%0d required=0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
